// File: rtl/psum_drain.sv
// psum_drain: drains the psum bank array. It accepts one read request per
// cycle, issues a 1-cycle-latency bank read, buffers the returned words in a
// small FIFO for a valid/ready stream, and tracks the per-operation maximum.
module psum_drain #(
  parameter int SMALL_BANK_COUNT = 3,
  parameter int BIG_BANK_COUNT   = 3,
  parameter int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
  parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT),
  parameter int ADDR_WIDTH       = 8,
  parameter int GPR_WIDTH        = 6,
  parameter int DATA_WIDTH       = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   new_stage,
  input  logic [GPR_WIDTH-1:0]                   operation_id,
  input  logic                                   rd_req_valid,
  input  logic [BANK_INDEX_WIDTH-1:0]            rd_bank_index,
  input  logic [ADDR_WIDTH-1:0]                  rd_address,
  input  logic                                   rd_last,
  output logic                                   rd_req_ready,
  output logic                                   bank_rd_en,
  output logic [BANK_INDEX_WIDTH-1:0]            bank_rd_bank,
  output logic [ADDR_WIDTH-1:0]                  bank_rd_addr,
  input  logic [TOTAL_BANK_COUNT*DATA_WIDTH-1:0] bank_rd_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic                                   out_last,
  output logic                                   result_valid,
  output logic [DATA_WIDTH-1:0]                  best_score,
  output logic [BANK_INDEX_WIDTH-1:0]            best_bank,
  output logic [ADDR_WIDTH-1:0]                  best_addr,
  output logic [GPR_WIDTH-1:0]                   result_op_id,
  output logic                                   busy,
  output logic                                   err_bank
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                            r_state;
  logic                                  r_inflight;
  logic [BANK_INDEX_WIDTH-1:0]           r_tag_bank;
  logic [ADDR_WIDTH-1:0]                 r_tag_addr;
  logic                                  r_tag_last;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [FIFO_DEPTH-1:0]                 r_mem_last;
  logic [PW-1:0]                         r_wptr;
  logic [PW-1:0]                         r_rptr;
  logic [CW-1:0]                         r_count;
  logic [DATA_WIDTH-1:0]                 r_best_score;
  logic [BANK_INDEX_WIDTH-1:0]           r_best_bank;
  logic [ADDR_WIDTH-1:0]                 r_best_addr;
  logic [DATA_WIDTH-1:0]                 r_res_score;
  logic [BANK_INDEX_WIDTH-1:0]           r_res_bank;
  logic [ADDR_WIDTH-1:0]                 r_res_addr;
  logic [GPR_WIDTH-1:0]                  r_op_id;
  logic                                  r_err;

  logic                  w_start;
  logic                  w_bank_ok;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_done_evt;
  logic [DATA_WIDTH-1:0] w_ret_data;

  // Occupancy counts the in-flight read so a returning word always has a slot;
  // a same-cycle pop is deliberately not credited.
  assign rd_req_ready = (r_state == S_DRAIN) &&
                        (({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(FIFO_DEPTH));
  assign w_start      = new_stage && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_bank_ok    = {1'b0, rd_bank_index} < (BANK_INDEX_WIDTH+1)'(TOTAL_BANK_COUNT);
  assign w_acc        = rd_req_valid && rd_req_ready;
  assign bank_rd_en   = w_acc && w_bank_ok;
  assign bank_rd_bank = rd_bank_index;
  assign bank_rd_addr = rd_address;

  assign out_valid    = (r_count != '0);
  assign out_data     = r_mem[r_rptr];
  assign out_last     = r_mem_last[r_rptr];
  assign w_pop        = out_valid && out_ready;
  assign w_done_evt   = (r_state == S_FLUSH) && w_pop && out_last;

  assign result_valid = (r_state == S_DONE);
  assign busy         = (r_state == S_DRAIN) || (r_state == S_FLUSH);
  assign best_score   = r_res_score;
  assign best_bank    = r_res_bank;
  assign best_addr    = r_res_addr;
  assign result_op_id = r_op_id;
  assign err_bank     = r_err;

  // Select the returning bank slice; an out-of-range tag yields zero.
  always_comb begin
    w_ret_data = '0;
    for (int k = 0; k < TOTAL_BANK_COUNT; k++)
      if (r_tag_bank == BANK_INDEX_WIDTH'(k))
        w_ret_data = bank_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Control FSM, read tag, error flag and running-maximum tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_inflight   <= 1'b0;
      r_tag_bank   <= '0;
      r_tag_addr   <= '0;
      r_tag_last   <= 1'b0;
      r_best_score <= MIN_SCORE;
      r_best_bank  <= '0;
      r_best_addr  <= '0;
      r_res_score  <= '0;
      r_res_bank   <= '0;
      r_res_addr   <= '0;
      r_op_id      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) r_state <= S_DRAIN;
        S_DRAIN: if (w_acc && rd_last) r_state <= S_FLUSH;
        S_FLUSH: if (w_done_evt) r_state <= S_DONE;
        default: r_state <= w_start ? S_DRAIN : S_IDLE;
      endcase
      if (w_start) begin
        r_op_id      <= operation_id;
        r_best_score <= MIN_SCORE;
        r_best_bank  <= '0;
        r_best_addr  <= '0;
        r_err        <= 1'b0;
      end
      r_inflight <= w_acc;
      if (w_acc) begin
        r_tag_bank <= rd_bank_index;
        r_tag_addr <= rd_address;
        r_tag_last <= rd_last;
        if (!w_bank_ok) r_err <= 1'b1;
      end
      // Strict compare: on a tie the earliest returned word keeps the title.
      if (r_inflight && ($signed(w_ret_data) > $signed(r_best_score))) begin
        r_best_score <= w_ret_data;
        r_best_bank  <= r_tag_bank;
        r_best_addr  <= r_tag_addr;
      end
      if (w_done_evt) begin
        r_res_score <= r_best_score;
        r_res_bank  <= r_best_bank;
        r_res_addr  <= r_best_addr;
      end
    end
  end

  // Output FIFO: push on the read return, pop on handshake; both may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem      <= '0;
      r_mem_last <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wptr]      <= w_ret_data;
        r_mem_last[r_wptr] <= r_tag_last;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{(CW-1){1'b0}}, r_inflight} - {{(CW-1){1'b0}}, w_pop};
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed and random operations checked cycle by cycle
// against an occupancy/queue reference model of the drain behaviour.
module tb_psum_drain;
  localparam int NB = 6, AW = 8, DW = 16, GW = 6, BW = 3, D = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            new_stage;
  logic [GW-1:0]   operation_id;
  logic            rd_req_valid;
  logic [BW-1:0]   rd_bank_index;
  logic [AW-1:0]   rd_address;
  logic            rd_last;
  logic            rd_req_ready;
  logic            bank_rd_en;
  logic [BW-1:0]   bank_rd_bank;
  logic [AW-1:0]   bank_rd_addr;
  logic [NB*DW-1:0] bank_rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            result_valid;
  logic [DW-1:0]   best_score;
  logic [BW-1:0]   best_bank;
  logic [AW-1:0]   best_addr;
  logic [GW-1:0]   result_op_id;
  logic            busy;
  logic            err_bank;

  psum_drain dut (
    .clk(clk), .reset(reset), .new_stage(new_stage), .operation_id(operation_id),
    .rd_req_valid(rd_req_valid), .rd_bank_index(rd_bank_index), .rd_address(rd_address),
    .rd_last(rd_last), .rd_req_ready(rd_req_ready), .bank_rd_en(bank_rd_en),
    .bank_rd_bank(bank_rd_bank), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .result_valid(result_valid), .best_score(best_score), .best_bank(best_bank),
    .best_addr(best_addr), .result_op_id(result_op_id), .busy(busy), .err_bank(err_bank)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  logic signed [DW-1:0] mem [NB][256];
  int rb[$];
  int ra[$];

  // Bank array model: 1-cycle read latency; stale non-zero data otherwise.
  always @(posedge clk) begin
    if (reset) bank_rd_data <= {NB{16'h5a5a}};
    else if (bank_rd_en)
      for (int k = 0; k < NB; k++) bank_rd_data[k*DW +: DW] <= mem[k][bank_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation over the requests in rb/ra.
  // mode 0: out_ready=1, 1: random, 2: held low for 12 cycles then 1.
  task automatic do_op(input int opid, input int mode, input bit glitch);
    int n, idx, popped, cyc, prev_acc, bb, ba;
    bit err, exp_rdy, acc;
    logic signed [DW-1:0] best;
    logic [DW-1:0] w;
    logic [DW:0] exp_q[$];
    logic [DW:0] e;
    n = rb.size(); idx = 0; popped = 0; cyc = 0; prev_acc = 0; err = 0;
    best = 16'sh8000; bb = 0; ba = 0;
    for (int i = 0; i < n; i++) begin
      w = (rb[i] < NB) ? mem[rb[i]][ra[i]] : '0;
      if ($signed(w) > best) begin best = w; bb = rb[i]; ba = ra[i]; end
    end
    @(negedge clk);
    new_stage = 1'b1; operation_id = GW'(opid); rd_req_valid = 1'b0; out_ready = 1'b0;
    #1 chk("busy_idle", busy, 0);
    while (popped < n) begin
      if (cyc > 3000) begin chk("timeout", popped, n); break; end
      @(negedge clk);
      new_stage     = glitch && (cyc == 2);
      operation_id  = (glitch && cyc == 2) ? GW'(opid) ^ 6'h15 : GW'(opid);
      rd_req_valid  = idx < n;
      rd_bank_index = (idx < n) ? BW'(rb[idx]) : BW'($urandom);
      rd_address    = (idx < n) ? AW'(ra[idx]) : AW'($urandom);
      rd_last       = (idx == n - 1);
      out_ready     = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : (cyc >= 12);
      #1;
      exp_rdy = (idx < n) && ((idx - popped) < D);
      acc = exp_rdy;
      chk("rd_req_ready", rd_req_ready, exp_rdy);
      chk("bank_rd_en", bank_rd_en, acc && rb[idx] < NB);
      if (acc && rb[idx] < NB) begin
        chk("bank_rd_bank", bank_rd_bank, rb[idx]);
        chk("bank_rd_addr", bank_rd_addr, ra[idx]);
      end
      chk("busy", busy, 1);
      chk("err_bank", err_bank, err);
      chk("result_valid_low", result_valid, 0);
      chk("result_op_id", result_op_id, opid);
      chk("out_valid", out_valid, (idx - prev_acc - popped) > 0);
      if (mode == 2 && cyc == 11) chk("hold_accepts", idx, D);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_pop", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[DW-1:0]);
          chk("out_last", out_last, e[DW]);
        end
        popped++;
      end
      if (acc) begin
        w = (rb[idx] < NB) ? mem[rb[idx]][ra[idx]] : '0;
        exp_q.push_back({idx == n - 1, w});
        if (rb[idx] >= NB) err = 1;
        idx++;
      end
      prev_acc = acc;
      cyc++;
    end
    @(negedge clk);
    new_stage = 1'b0; rd_req_valid = 1'b0;
    #1;
    chk("result_valid", result_valid, 1);
    chk("best_score", best_score, $unsigned(best));
    chk("best_bank", best_bank, bb);
    chk("best_addr", best_addr, ba);
    chk("result_op_id_done", result_op_id, opid);
    chk("busy_done", busy, 0);
    @(negedge clk);
    #1;
    chk("result_valid_pulse", result_valid, 0);
    chk("err_bank_sticky", err_bank, err);
    rb.delete(); ra.delete();
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = DW'($urandom);
    reset = 1'b1; new_stage = 0; operation_id = 0; rd_req_valid = 0;
    rd_bank_index = 0; rd_address = 0; rd_last = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", rd_req_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_err", err_bank, 0);
    chk("rst_op_id", result_op_id, 0);
    reset = 1'b0;

    // Basic drain, tie resolves to earliest address.
    mem[1][0] = 5; mem[1][1] = -2; mem[1][2] = 9; mem[1][3] = 9;
    for (int i = 0; i < 4; i++) begin rb.push_back(1); ra.push_back(i); end
    do_op(1, 0, 0);

    // Backpressure: only FIFO_DEPTH accepted while out_ready is low.
    for (int i = 0; i < 6; i++) begin rb.push_back(2); ra.push_back(30 + i); end
    do_op(5, 2, 0);

    // All-equal negative words across two banks.
    for (int i = 0; i < 5; i++) begin
      mem[3 + (i % 2)][20 + i] = -3;
      rb.push_back(3 + (i % 2)); ra.push_back(20 + i);
    end
    do_op(2, 0, 0);

    // Out-of-range bank, then err cleared by the next operation's start.
    rb.push_back(0); ra.push_back(7);
    rb.push_back(7); ra.push_back(8);
    rb.push_back(2); ra.push_back(9);
    do_op(3, 1, 0);

    // new_stage mid-drain must be ignored.
    for (int i = 0; i < 5; i++) begin rb.push_back(i); ra.push_back(40 + i); end
    do_op(4, 0, 1);

    // Reset in FLUSH with two words buffered.
    @(negedge clk);
    new_stage = 1; operation_id = 9;
    @(negedge clk);
    new_stage = 0; out_ready = 0;
    rd_req_valid = 1; rd_bank_index = 0; rd_address = 10; rd_last = 0;
    @(negedge clk);
    rd_address = 11; rd_last = 1;
    @(negedge clk);
    rd_req_valid = 0; rd_last = 0;
    @(negedge clk);
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result_valid", result_valid, 0);
    chk("mid_rst_op_id", result_op_id, 0);
    @(negedge clk);
    reset = 1'b0;

    // Random operations.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = 1 + ($urandom % 10);
      for (int i = 0; i < n; i++) begin
        rb.push_back($urandom % NB); ra.push_back($urandom % 256);
      end
      do_op(10 + r, 1, (n >= 3) && r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
Downstream consumer of the partial-sum bank manager's read side. Takes one read request per cycle (bank index and address) and issues a 1-cycle-latency read to the flattened psum bank array. Returned words are buffered in a small FIFO and streamed out with a valid/ready handshake. Tracks the per-operation maximum score and its location, and pulses a result when the last element of an operation has left the block.

Parameters:
SMALL_BANK_COUNT, 3, number of small psum banks
BIG_BANK_COUNT, 3, number of big psum banks
TOTAL_BANK_COUNT, 6, SMALL_BANK_COUNT + BIG_BANK_COUNT
BANK_INDEX_WIDTH, 3, $clog2(TOTAL_BANK_COUNT)
ADDR_WIDTH, 8, psum bank address width
GPR_WIDTH, 6, operation id width
DATA_WIDTH, 16, signed psum word width
FIFO_DEPTH, 4, output buffer depth (power of 2, ≥2)

Ports:
clk  in  1  single clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
new_stage  in  1  start pulse; honoured only in IDLE/DONE
operation_id  in  GPR_WIDTH  id latched on an accepted new_stage
rd_req_valid  in  1  read request from manager (read_bank_valid)
rd_bank_index  in  BANK_INDEX_WIDTH  bank to read
rd_address  in  ADDR_WIDTH  address within bank
rd_last  in  1  qualifies the final request of the operation
rd_req_ready  out  1  request accepted when valid&&ready; manager stall = ~rd_req_ready
bank_rd_en  out  1  bank read strobe
bank_rd_bank  out  BANK_INDEX_WIDTH  bank select
bank_rd_addr  out  ADDR_WIDTH  bank address
bank_rd_data  in  TOTAL_BANK_COUNT*DATA_WIDTH  all bank outputs; bank k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after bank_rd_en
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_WIDTH  psum word
out_last  out  1  marks final word of the operation
result_valid  out  1  1-cycle pulse in DONE
best_score  out  DATA_WIDTH  signed maximum of the operation
best_bank  out  BANK_INDEX_WIDTH  bank index of the maximum
best_addr  out  ADDR_WIDTH  address of the maximum
result_op_id  out  GPR_WIDTH  latched operation_id
busy  out  1  high in DRAIN/FLUSH
err_bank  out  1  sticky; set by an out-of-range bank request; cleared by reset or an accepted new_stage

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; in-flight flag 0; best_score = most-negative value (internal).
- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE/DONE + new_stage → DRAIN. Latch operation_id, reset best_score to the most-negative value, clear best_bank/best_addr and err_bank.
- new_stage in DRAIN/FLUSH is ignored.
- rd_req_ready = (state==DRAIN) && (fifo_count + inflight < FIFO_DEPTH). fifo_count is taken at the start of the cycle; a same-cycle pop does not count (conservative).
- Accept (rd_req_valid && rd_req_ready):
  - bank_rd_en = 1 combinationally that cycle, with bank_rd_bank = rd_bank_index and bank_rd_addr = rd_address.
  - Register the tag (bank, addr, last) and set inflight = 1 for the next cycle.
  - At most one accept per cycle.
- Out-of-range bank (rd_bank_index ≥ TOTAL_BANK_COUNT): request is still accepted, but bank_rd_en stays 0, the returned word is 0, and err_bank is set.
- Return cycle (inflight = 1):
  - Select bank_rd_data slice by the tag bank and push {data, last} into the FIFO. Space is guaranteed by the ready rule.
  - Update the maximum if data > best_score (strict signed compare, so on a tie the earliest return wins). Record the tag bank/addr.
- FIFO output: out_valid = !empty; out_data/out_last come from the head. Pop on out_valid && out_ready. Push and pop in the same cycle are both honoured, including at full and at empty+push (the word appears one cycle later, with no bypass).
- Accept with rd_last → FLUSH. No further requests are accepted.
- FLUSH → DONE on the pop of the word with out_last = 1.
- DONE lasts 1 cycle: result_valid = 1; best_* and result_op_id hold until the next accepted new_stage. Then → IDLE, unless new_stage is present, which goes directly to DRAIN.
- Asynchronous reset mid-operation discards the FIFO, the in-flight read and the tracker. No result is produced.

Test Plan:
- new_stage, op_id 1; 4 requests to bank 1 at addr 0..3, last on addr 3; bank 1 data 5, -2, 9, 9; out_ready = 1 → out_data 5, -2, 9, 9; out_last on the 4th word; result_valid 1 cycle later with best_score 9, best_bank 1, best_addr 2, result_op_id 1.
- out_ready = 0, 6 back-to-back requests → exactly 4 accepted and rd_req_ready stays low. Raise out_ready → the remaining 2 are accepted, with no loss or duplication.
- All words -3 across banks 3 and 4, op_id 2 → best_score -3 at the first bank/addr returned.
- Request to bank 7 (value 0 elsewhere) → bank_rd_en 0, out_data 0, err_bank 1 until the next new_stage.
- Reset asserted in FLUSH with 2 words buffered → out_valid, busy and result_valid drop immediately. A subsequent operation produces correct results.
- new_stage during DRAIN with a different op_id → ignored; result_op_id keeps the original value.
